// File: rtl/aer_in_arbiter.sv
// Two-source round-robin arbiter sharing the core's 4-phase AER input link.
// Each source gets a private 4-phase slave handshake. All REQ/ACK inputs are synchronised first.
module aer_in_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] SRC0_ADDR,
    input  logic              SRC0_REQ,
    output logic              SRC0_ACK,
    input  logic [ADDR_W-1:0] SRC1_ADDR,
    input  logic              SRC1_REQ,
    output logic              SRC1_ACK,
    input  logic [1:0]        SRC_EN,
    output logic [ADDR_W-1:0] AERIN_ADDR,
    output logic              AERIN_REQ,
    input  logic              AERIN_ACK,
    output logic              GRANT_ID,
    output logic              BUSY,
    input  logic              CLR_CNT,
    output logic [CNT_W-1:0]  EVT_CNT0,
    output logic [CNT_W-1:0]  EVT_CNT1,
    output logic              ERR_TIMEOUT
);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK_H, WAIT_REL} state_t;

    localparam int SC_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] req0_sync_q, req1_sync_q, ack_sync_q;
    logic                   req0_s, req1_s, ack_s;

    state_t            state_q;
    logic [SC_W-1:0]   setup_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              gid_q, busy_q, areq_q, ack0_q, ack1_q, rr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              err_q, err_d;

    logic elig0, elig1, win, win_req_s, rel_now, to_hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req0_sync_q <= '0;
            req1_sync_q <= '0;
            ack_sync_q  <= '0;
        end else begin
            req0_sync_q[0] <= SRC0_REQ;
            req1_sync_q[0] <= SRC1_REQ;
            ack_sync_q[0]  <= AERIN_ACK;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req0_sync_q[i] <= req0_sync_q[i-1];
                req1_sync_q[i] <= req1_sync_q[i-1];
                ack_sync_q[i]  <= ack_sync_q[i-1];
            end
        end
    end

    assign req0_s = req0_sync_q[SYNC_STAGES-1];
    assign req1_s = req1_sync_q[SYNC_STAGES-1];
    assign ack_s  = ack_sync_q[SYNC_STAGES-1];

    always_comb begin
        elig0     = req0_s & SRC_EN[0];
        elig1     = req1_s & SRC_EN[1];
        // With a single eligible source the winner is simply that source.
        win       = (elig0 & elig1) ? rr_q : elig1;
        win_req_s = gid_q ? req1_s : req0_s;
        rel_now   = (state_q == WAIT_REL) && !ack_s && !win_req_s;
        to_hit    = (state_q == WAIT_ACK_H) && !ack_s &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        err_d  = err_q | to_hit;
        if (rel_now && !gid_q && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + 1'b1;
        if (rel_now &&  gid_q && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
        if (CLR_CNT) begin
            cnt0_d = '0;
            cnt1_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            gid_q       <= 1'b0;
            busy_q      <= 1'b0;
            areq_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rr_q        <= 1'b0;
            addr_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (elig0 | elig1) begin
                        addr_q      <= win ? SRC1_ADDR : SRC0_ADDR;
                        gid_q       <= win;
                        busy_q      <= 1'b1;
                        setup_cnt_q <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt_q == SC_W'(SETUP_CYCLES - 1)) begin
                        areq_q   <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= WAIT_ACK_H;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 1'b1;
                    end
                end
                WAIT_ACK_H: begin
                    if (ack_s) begin
                        areq_q  <= 1'b0;
                        ack0_q  <= ~gid_q;
                        ack1_q  <= gid_q;
                        state_q <= WAIT_REL;
                    end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
                        // Timeout only flags an error; the transaction is never abandoned.
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (rel_now) begin
                        ack0_q  <= 1'b0;
                        ack1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        rr_q    <= ~gid_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            err_q  <= err_d;
        end
    end

    assign SRC0_ACK    = ack0_q;
    assign SRC1_ACK    = ack1_q;
    assign AERIN_ADDR  = addr_q;
    assign AERIN_REQ   = areq_q;
    assign GRANT_ID    = gid_q;
    assign BUSY        = busy_q;
    assign EVT_CNT0    = cnt0_q;
    assign EVT_CNT1    = cnt1_q;
    assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_aer_in_arbiter.sv
// Scoreboard bench for aer_in_arbiter: per-source address queues, round-robin reference and directed corner cases.
module tb_aer_in_arbiter;
    localparam int AW = 10;
    localparam int CW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s0_addr, s1_addr, a_addr;
    logic          s0_req, s1_req, s0_ack, s1_ack;
    logic [1:0]    src_en;
    logic          areq, aack, gid, busy, clr, err;
    logic [CW-1:0] cnt0, cnt1;

    aer_in_arbiter #(
        .ADDR_W(AW), .SYNC_STAGES(2), .SETUP_CYCLES(1), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .CLK(clk), .RST(rst),
        .SRC0_ADDR(s0_addr), .SRC0_REQ(s0_req), .SRC0_ACK(s0_ack),
        .SRC1_ADDR(s1_addr), .SRC1_REQ(s1_req), .SRC1_ACK(s1_ack),
        .SRC_EN(src_en),
        .AERIN_ADDR(a_addr), .AERIN_REQ(areq), .AERIN_ACK(aack),
        .GRANT_ID(gid), .BUSY(busy), .CLR_CNT(clr),
        .EVT_CNT0(cnt0), .EVT_CNT1(cnt1), .ERR_TIMEOUT(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [AW-1:0] q0[$];
    logic [AW-1:0] q1[$];
    bit            pend[2];
    int unsigned   pend_t[2];
    bit            rr_model  = 1'b0;
    bit            fair_chk  = 1'b0;
    bit            core_auto = 1'b0;
    int            core_lat  = -1;
    int            grant_log[$];
    int            rises = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return areq;
            1:       return s0_ack;
            2:       return s1_ack;
            3:       return busy;
            default: return err;
        endcase
    endfunction

    // Returns on the first falling edge where the signal holds val, or after maxc cycles.
    task automatic wait_sig(input int which, input logic val, input int maxc, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (sig(which) !== val && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(sig(which)), 32'(val));
    endtask

    task automatic src_raise(input int n, input logic [AW-1:0] a);
        @(posedge clk);
        #1;
        if (n == 0) begin
            s0_addr = a; s0_req = 1'b1; q0.push_back(a);
        end else begin
            s1_addr = a; s1_req = 1'b1; q1.push_back(a);
        end
        pend[n]   = 1'b1;
        pend_t[n] = cyc;
    endtask

    task automatic src_drop(input int n);
        @(posedge clk);
        #1;
        if (n == 0) s0_req = 1'b0;
        else        s1_req = 1'b0;
    endtask

    task automatic src_txn(input int n, input logic [AW-1:0] a, input int hold);
        src_raise(n, a);
        wait_sig(n + 1, 1'b1, 400, "src_ack_rise");
        repeat (hold) @(posedge clk);
        src_drop(n);
        wait_sig(n + 1, 1'b0, 100, "src_ack_fall");
    endtask

    task automatic src_loop(input int n, input int cnt, input int addr, input int maxgap, input int maxhold);
        logic [AW-1:0] a;
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            a = (addr < 0) ? AW'($urandom) : AW'(addr);
            src_txn(n, a, int'($urandom_range(0, maxhold)));
        end
    endtask

    task automatic do_reset();
        core_auto = 1'b0;
        @(negedge clk);
        aack = 1'b0; s0_req = 1'b0; s1_req = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        q0.delete(); q1.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        rr_model = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops the expected address of the granted source at every core REQ rise.
    initial begin
        logic          p_areq, p_a0, p_a1;
        int            w;
        logic [AW-1:0] e;
        p_areq = 1'b0; p_a0 = 1'b0; p_a1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_areq = 1'b0; p_a0 = 1'b0; p_a1 = 1'b0;
            end else begin
                if (areq && !p_areq) begin
                    w = int'(gid);
                    rises++;
                    grant_log.push_back(w);
                    chk("busy_at_req", 32'(busy), 32'(1));
                    if (w == 0) begin
                        chk("src0_pending_at_grant", 32'(q0.size() > 0), 32'(1));
                        if (q0.size() > 0) begin e = q0.pop_front(); chk("addr_src0", 32'(a_addr), 32'(e)); end
                    end else begin
                        chk("src1_pending_at_grant", 32'(q1.size() > 0), 32'(1));
                        if (q1.size() > 0) begin e = q1.pop_front(); chk("addr_src1", 32'(a_addr), 32'(e)); end
                    end
                    if (fair_chk && pend[1-w] && cyc >= pend_t[1-w] + 5)
                        chk("rr_winner", 32'(w), 32'(rr_model));
                    pend[w] = 1'b0;
                end
                if (s0_ack && !p_a0) begin
                    chk("ack0_owner", 32'(gid), 32'(0));
                    chk("ack0_areq_low", 32'(areq), 32'(0));
                end
                if (s1_ack && !p_a1) begin
                    chk("ack1_owner", 32'(gid), 32'(1));
                    chk("ack1_areq_low", 32'(areq), 32'(0));
                end
                if (!s0_ack && p_a0) rr_model = 1'b1;
                if (!s1_ack && p_a1) rr_model = 1'b0;
                p_areq = areq; p_a0 = s0_ack; p_a1 = s1_ack;
            end
        end
    end

    // Core model: acknowledges each request after a latency, releases once REQ drops.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (core_auto && !rst && areq && !aack) begin
                lat = (core_lat < 0) ? int'($urandom_range(0, 10)) : core_lat;
                repeat (lat) @(posedge clk);
                #1 aack = 1'b1;
                wait_sig(0, 1'b0, 40, "core_req_drop");
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 aack = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: stopped at cycle %0d, required completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, gl, n0, n1;
        rst = 1'b1; s0_addr = '0; s1_addr = '0; s0_req = 1'b0; s1_req = 1'b0;
        src_en = 2'b00; aack = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_areq", 32'(areq), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_acks", 32'({s1_ack, s0_ack}), 32'(0));
        chk("rst_addr", 32'(a_addr), 32'(0));
        chk("rst_cnts", 32'({cnt1, cnt0}), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        rst = 1'b0;

        // Single event with a slow manual core.
        src_en = 2'b11;
        src_raise(0, 10'h2A3);
        wait_sig(0, 1'b1, 20, "single_req");
        repeat (25) @(posedge clk);
        #1 aack = 1'b1;
        wait_sig(1, 1'b1, 10, "single_ack0");
        chk("single_areq_low", 32'(areq), 32'(0));
        @(posedge clk);
        #1 s0_req = 1'b0; aack = 1'b0;
        wait_sig(1, 1'b0, 10, "single_ack0_fall");
        chk("single_cnt0", 32'(cnt0), 32'(1));
        chk("single_gid", 32'(gid), 32'(0));
        chk("single_busy", 32'(busy), 32'(0));

        // Contention: both sources always requesting.
        do_reset();
        src_en = 2'b11; fair_chk = 1'b1; core_lat = 10; core_auto = 1'b1;
        grant_log.delete();
        fork
            src_loop(0, 3, 'h011, 0, 0);
            src_loop(1, 3, 'h322, 0, 0);
        join
        chk("contention_n", 32'(grant_log.size()), 32'(6));
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("contention_order", 32'(grant_log[i]), 32'(i % 2));
        chk("contention_cnt0", 32'(cnt0), 32'(3));
        chk("contention_cnt1", 32'(cnt1), 32'(3));

        // Mask: disabled source is never granted; disabling mid-transaction completes it.
        do_reset();
        src_en = 2'b01; fair_chk = 1'b0; core_lat = -1;
        r0 = rises;
        src_raise(1, 10'h155);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("mask_no_grant", 32'(rises), 32'(r0));
        chk("mask_ack1_low", 32'(s1_ack), 32'(0));
        src_en = 2'b11; core_auto = 1'b1;
        wait_sig(2, 1'b1, 50, "mask_ack1");
        src_drop(1);
        wait_sig(2, 1'b0, 50, "mask_ack1_fall");
        core_auto = 1'b0;
        src_raise(0, 10'h0F0);
        wait_sig(0, 1'b1, 20, "mask_src0_req");
        src_en = 2'b10; core_auto = 1'b1;
        wait_sig(1, 1'b1, 30, "mask_ack0");
        src_drop(0);
        wait_sig(1, 1'b0, 30, "mask_ack0_fall");
        chk("mask_cnt0", 32'(cnt0), 32'(1));
        chk("mask_cnt1", 32'(cnt1), 32'(1));
        src_en = 2'b11;

        // Timeout: core silent, error flags at the 64th cycle of waiting, then late ACK.
        core_auto = 1'b0;
        src_raise(1, 10'h3C3);
        wait_sig(0, 1'b1, 20, "to_req");
        repeat (TO - 1) @(negedge clk);
        chk("to_err_early", 32'(err), 32'(0));
        @(negedge clk);
        chk("to_err_set", 32'(err), 32'(1));
        chk("to_areq_held", 32'(areq), 32'(1));
        repeat (40) @(negedge clk);
        chk("to_still_waiting", 32'(areq), 32'(1));
        core_auto = 1'b1;
        wait_sig(2, 1'b1, 30, "to_late_ack");
        src_drop(1);
        wait_sig(2, 1'b0, 30, "to_ack_fall");
        chk("to_cnt1", 32'(cnt1), 32'(2));
        chk("to_err_sticky", 32'(err), 32'(1));
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_err", 32'(err), 32'(0));
        chk("clr_cnts", 32'({cnt1, cnt0}), 32'(0));

        // Saturation, then a clear landing on the same edge as a completion.
        src_loop(0, 17, -1, 3, 2);
        chk("sat_cnt0", 32'(cnt0), 32'(15));
        core_auto = 1'b0;
        src_raise(0, 10'h0AA);
        wait_sig(0, 1'b1, 20, "coinc_req");
        @(posedge clk);
        #1 aack = 1'b1;
        wait_sig(1, 1'b1, 10, "coinc_ack0");
        src_drop(0);
        repeat (4) @(posedge clk);
        #1 aack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        chk("coinc_still_rel", 32'(s0_ack), 32'(1));
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("coinc_done", 32'(s0_ack), 32'(0));
        chk("coinc_cnt0", 32'(cnt0), 32'(0));

        // Reset in the middle of a release phase.
        core_auto = 1'b1;
        src_txn(1, 10'h2B2, 0);
        core_auto = 1'b0;
        chk("pre_rst_cnt1", 32'(cnt1), 32'(1));
        src_raise(0, 10'h1AB);
        wait_sig(0, 1'b1, 20, "mid_req");
        @(posedge clk);
        #1 aack = 1'b1;
        wait_sig(1, 1'b1, 10, "mid_ack0");
        #2 rst = 1'b1;
        #1;
        chk("mid_areq", 32'(areq), 32'(0));
        chk("mid_ack0", 32'(s0_ack), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_gid", 32'(gid), 32'(0));
        chk("mid_cnts", 32'({cnt1, cnt0}), 32'(0));
        s0_req = 1'b0; aack = 1'b0;
        q0.delete(); q1.delete(); pend[0] = 1'b0; pend[1] = 1'b0; rr_model = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fair_chk = 1'b1; core_auto = 1'b1;
        gl = grant_log.size();
        fork
            src_txn(0, 10'h101, 0);
            src_txn(1, 10'h202, 0);
        join
        chk("post_rst_n", 32'(grant_log.size()), 32'(gl + 2));
        if (grant_log.size() >= gl + 2) begin
            chk("post_rst_first", 32'(grant_log[gl]), 32'(0));
            chk("post_rst_second", 32'(grant_log[gl+1]), 32'(1));
        end

        // Randomised traffic from both sources.
        do_reset();
        src_en = 2'b11; fair_chk = 1'b1; core_lat = -1; core_auto = 1'b1;
        n0 = int'($urandom_range(5, 14));
        n1 = int'($urandom_range(5, 14));
        fork
            src_loop(0, n0, -1, 8, 4);
            src_loop(1, n1, -1, 8, 4);
        join
        chk("rand_cnt0", 32'(cnt0), 32'(n0));
        chk("rand_cnt1", 32'(cnt1), 32'(n1));
        chk("rand_q_empty", 32'(q0.size() + q1.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/aer_in_arbiter.md
Name: aer_in_arbiter

Overview:
- Two-requester arbiter for the core's 10-bit AER input link (AERIN_ADDR/REQ/ACK, 4-phase).
- Shares the link between the pixel encoder (source 0) and an off-chip/host AER source (source 1).
- Each source sees a private 4-phase slave handshake; the core sees a single 4-phase master.
- Round-robin fairness, per-source enable mask, per-source event counters and an ack-timeout error flag.

Parameters:
- ADDR_W, 10, AER address width (IMAGE_SIZE_BITS+2).
- SYNC_STAGES, 2, flip-flop stages on every incoming REQ/ACK (sources and core may be asynchronous).
- SETUP_CYCLES, 1, cycles AERIN_ADDR is held stable before AERIN_REQ rises (min 1).
- TIMEOUT_CYCLES, 4096, max cycles waiting for core ACK high before ERR_TIMEOUT sets.
- CNT_W, 16, width of per-source event counters.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- SRC0_ADDR  in  ADDR_W  encoder event address.
- SRC0_REQ  in  1  encoder request.
- SRC0_ACK  out  1  encoder acknowledge.
- SRC1_ADDR  in  ADDR_W  host event address.
- SRC1_REQ  in  1  host request.
- SRC1_ACK  out  1  host acknowledge.
- SRC_EN  in  2  per-source grant enable (bit i = source i).
- AERIN_ADDR  out  ADDR_W  address to core.
- AERIN_REQ  out  1  request to core.
- AERIN_ACK  in  1  acknowledge from core.
- GRANT_ID  out  1  source owning the link (valid while BUSY).
- BUSY  out  1  transaction in progress.
- CLR_CNT  in  1  synchronous clear of counters and ERR_TIMEOUT.
- EVT_CNT0  out  CNT_W  completed events from source 0.
- EVT_CNT1  out  CNT_W  completed events from source 1.
- ERR_TIMEOUT  out  1  sticky: core ACK did not rise within TIMEOUT_CYCLES.

Behaviour:
- Reset: all outputs 0, FSM IDLE, rr pointer = 0 (source 0 favoured first), sync chains cleared.
- reqN_s and ack_s are the SYNC_STAGES-deep synchronised SRCn_REQ and AERIN_ACK. Decisions use only synchronised values.
- IDLE:
  - Eligible = reqN_s & SRC_EN[N].
  - One eligible: grant it. Both eligible: grant source == rr pointer.
  - On grant, at the same edge: latch the winner's SRCn_ADDR into AERIN_ADDR; GRANT_ID = winner; BUSY = 1; go SETUP.
- SETUP: hold for SETUP_CYCLES; at the last edge assert AERIN_REQ and go WAIT_ACK_H. AERIN_REQ rises SETUP_CYCLES edges after the grant edge.
- WAIT_ACK_H:
  - On ack_s = 1 at the same edge: AERIN_REQ = 0, SRCn_ACK = 1 for the winner, go WAIT_REL.
  - A timeout counter runs in this state. When it reaches TIMEOUT_CYCLES, ERR_TIMEOUT = 1 (sticky); the FSM keeps waiting and never abandons the transaction.
- WAIT_REL: wait until ack_s = 0 AND the winner's req_s = 0 (either order). Then, at the same edge:
  - SRCn_ACK = 0, BUSY = 0.
  - Winner's counter increments.
  - rr pointer = other source.
  - go IDLE.
- Next grant is no earlier than the edge after IDLE is re-entered. No back-to-back grant in the WAIT_REL exit cycle.
- AERIN_ADDR is stable from the grant until the next grant. It changes only in IDLE on a grant.
- SRC_EN changes affect only IDLE arbitration. A source disabled mid-transaction still completes normally.
- A non-granted source's ACK stays 0 regardless of its REQ. Its request stays pending with no loss.
- A source dropping REQ before ACK (protocol violation) is ignored until WAIT_REL; no ACK pulse is lost or duplicated.
- Counters:
  - Saturate at 2^CNT_W-1.
  - CLR_CNT clears both counters and ERR_TIMEOUT, with priority over a simultaneous increment or set.
- RST mid-transaction: immediate return to reset values. AERIN_REQ and SRCn_ACK drop asynchronously. Sources and core must restart their handshakes.

Test Plan:
- Single event: SRC_EN=2'b11, SRC0_ADDR=10'h2A3, SRC0_REQ↑ → AERIN_ADDR=10'h2A3 before AERIN_REQ↑; core ACK after 25 cycles → SRC0_ACK↑ with AERIN_REQ↓; SRC0_REQ↓ and ACK↓ → SRC0_ACK↓; EVT_CNT0=1, GRANT_ID=0.
- Contention: both REQ held high from reset, addresses 10'h011 (src0) and 10'h322 (src1), auto-ack core with 100 ns latency → 6 transactions served in order 0,1,0,1,0,1; EVT_CNT0=EVT_CNT1=3.
- Mask: SRC_EN=2'b01, SRC1_REQ high → no SRC1 grant for 1000 cycles; set SRC_EN=2'b11 → SRC1 granted next; also clear SRC_EN[0] mid-transaction → that transaction completes and EVT_CNT0 increments.
- Timeout: TIMEOUT_CYCLES=64, core never acks → ERR_TIMEOUT=1 at cycle 64 of WAIT_ACK_H, AERIN_REQ stays 1; late ACK → normal completion; CLR_CNT → ERR_TIMEOUT=0 and counters 0.
- Reset mid-op: assert RST while in WAIT_REL (SRC0_ACK=1) → AERIN_REQ, SRC0_ACK, BUSY, GRANT_ID, counters all 0 immediately; after release the next SRC1 request is granted first only if SRC0_REQ is low (rr pointer = 0).
- Saturation: CNT_W=4, 17 source-0 events → EVT_CNT0 holds 4'hF; CLR_CNT coincident with a completion → 0.
